// File: rtl/fifo_pkg.sv
// Shared types and sizing for the asynchronous FIFO read/write side stages.
// The prefetch buffer depth also fixes the request credit limit.
package fifo_pkg;

  localparam int DEFAULT_DATASIZE = 8;
  localparam int PREFETCH_DEPTH   = 2;
  localparam int CNT_W            = $clog2(PREFETCH_DEPTH + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ZERO = cnt_t'(0);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(PREFETCH_DEPTH);

  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_POP  = 2'b01,
    BUF_PUSH = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  function automatic buf_op_e buf_op(input logic push, input logic pop);
    return buf_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer; entry 0 is the head and is presented directly.
// Push and pop may coincide in the same cycle without changing the count.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DEFAULT_DATASIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output cnt_t         count
);

  logic [W-1:0] entry_reg  [PREFETCH_DEPTH];
  logic [W-1:0] entry_next [PREFETCH_DEPTH];
  cnt_t         count_reg;
  cnt_t         count_next;

  always_comb begin
    entry_next = entry_reg;
    count_next = count_reg;
    case (buf_op(push, pop))
      BUF_PUSH: begin
        if (count_reg == CNT_ZERO) begin
          entry_next[0] = din;
        end else begin
          entry_next[1] = din;
        end
        if (count_reg != CNT_FULL) begin
          count_next = count_reg + CNT_ONE;
        end
      end
      BUF_POP: begin
        entry_next[0] = entry_reg[1];
        if (count_reg != CNT_ZERO) begin
          count_next = count_reg - CNT_ONE;
        end
      end
      BUF_BOTH: begin
        // With a single word the incoming one simply replaces the head.
        if (count_reg == CNT_ONE) begin
          entry_next[0] = din;
        end else begin
          entry_next[0] = entry_reg[1];
          entry_next[1] = din;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PREFETCH_DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
      count_reg <= CNT_ZERO;
    end else begin
      for (int i = 0; i < PREFETCH_DEPTH; i++) begin
        entry_reg[i] <= entry_next[i];
      end
      count_reg <= count_next;
    end
  end

  assign head  = entry_reg[0];
  assign count = count_reg;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_reg == CNT_FULL));

  a_count_range : assert property (@(posedge clk) disable iff (rst)
    count_reg <= CNT_FULL);

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side output stage: issues rinc under a credit limit, captures memory
// data one cycle later and streams it out through a two-entry prefetch buffer.
module fifo_rd_prefetch
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DEFAULT_DATASIZE
) (
  input  logic                rclk,
  input  logic                r_rst,
  input  logic                rempty,
  output logic                rinc,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [1:0]          buf_count
);

  logic       pending_reg;
  logic       pending_next;
  logic       acc;
  logic       pop;
  logic [2:0] credit_sum;

  assign dout_valid = (buf_count != 2'd0);

  // Stored plus in-flight words after this cycle's pop must leave room for one more.
  always_comb begin
    pop          = dout_valid & dout_ready;
    credit_sum   = 3'(buf_count) + 3'(pending_reg) - 3'(pop);
    rinc         = !r_rst && !rempty && (credit_sum < 3'(PREFETCH_DEPTH));
    acc          = rinc & !rempty;
    pending_next = acc;
  end

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      pending_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  rd_skid_buf #(
    .W (DATASIZE)
  ) u_buf (
    .clk   (rclk),
    .rst   (r_rst),
    .push  (pending_reg),
    .pop   (pop),
    .din   (mem_rdata),
    .head  (dout),
    .count (buf_count)
  );

  a_dout_stable : assert property (@(posedge rclk) disable iff (r_rst)
    (dout_valid && !dout_ready) |=> $stable(dout));

  a_reset_values : assert property (@(posedge rclk)
    r_rst |-> (buf_count == 2'd0 && !dout_valid && dout == '0 && !rinc));

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Randomized bench for the read prefetch stage against a queue-based FIFO
// model and an in-order scoreboard of delivered words.
module tb_fifo_rd_prefetch;

  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          r_rst;
  logic          rempty = 1'b1;
  logic          rinc;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic [1:0]    buf_count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_q   [$];
  logic [DW-1:0] got_q   [$];
  logic          force_empty = 1'b0;
  logic          inflight    = 1'b0;
  int            acc_total   = 0;

  fifo_rd_prefetch #(
    .DATASIZE (DW)
  ) dut (
    .rclk       (rclk),
    .r_rst      (r_rst),
    .rempty     (rempty),
    .rinc       (rinc),
    .mem_rdata  (mem_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .buf_count  (buf_count)
  );

  always #5 rclk = ~rclk;

  // Environment: FIFO storage and read pointer, plus collection of delivered words.
  always @(posedge rclk) begin
    logic [DW-1:0] w;
    if (rinc && !rempty && mem_q.size() != 0) begin
      w = mem_q.pop_front();
      mem_rdata <= w;
      acc_total++;
      inflight  <= 1'b1;
    end else begin
      mem_rdata <= DW'($urandom);
      inflight  <= 1'b0;
    end
    if (dout_valid && dout_ready) got_q.push_back(dout);
    rempty <= (mem_q.size() == 0) || force_empty;
  end

  task automatic check_credit(input string tag);
    checks++;
    if (!r_rst && (int'(buf_count) + int'(inflight)) > 2) begin
      errors++;
      $display("FAIL %s_credit: buf_count=%0d inflight=%0d, required sum <= 2", tag, buf_count, inflight);
    end
  endtask

  task automatic drain();
    bit done = 0;
    dout_ready  = 1'b1;
    force_empty = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge rclk);
      if (mem_q.size() == 0 && buf_count == 2'd0 && !inflight) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: buf_count=%0d mem_left=%0d, required empty", buf_count, mem_q.size());
    end
    @(negedge rclk);
  endtask

  task automatic test_reset();
    r_rst      = 1'b1;
    dout_ready = 1'b1;
    repeat (3) begin
      @(negedge rclk);
      checks++;
      if (rinc !== 1'b0 || dout_valid !== 1'b0 || buf_count !== 2'd0 || dout !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold: rinc=%b valid=%b count=%0d dout=%h, required 0 0 0 00",
                 rinc, dout_valid, buf_count, dout);
      end
    end
    r_rst = 1'b0;
    repeat (3) begin
      @(negedge rclk);
      checks++;
      if (rinc !== 1'b0 || dout_valid !== 1'b0 || buf_count !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle: rinc=%b valid=%b count=%0d, required 0 0 0", rinc, dout_valid, buf_count);
      end
    end
  endtask

  task automatic test_latency();
    logic          r_a [10];
    logic          v_a [10];
    logic [DW-1:0] d_a [10];
    logic [DW-1:0] exp3 [3];
    int first_rinc = -1;
    int first_valid = -1;
    int n_rinc = 0;
    exp3 = '{8'h11, 8'h22, 8'h33};
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) mem_q.push_back(exp3[k]);
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      r_a[c] = rinc;
      v_a[c] = dout_valid;
      d_a[c] = dout;
      if (rinc) begin
        n_rinc++;
        if (first_rinc < 0) first_rinc = c;
      end
      if (dout_valid && first_valid < 0) first_valid = c;
    end
    checks++;
    if (n_rinc != 3 || first_rinc != 0) begin
      errors++;
      $display("FAIL latency_rinc: rinc_cycles=%0d first=%0d, required 3 starting at 0", n_rinc, first_rinc);
    end
    checks++;
    if (first_rinc < 0 || first_valid != first_rinc + 2) begin
      errors++;
      $display("FAIL latency_first: first_valid=%0d, required first_rinc+2=%0d", first_valid, first_rinc + 2);
    end
    if (first_valid >= 0 && first_valid <= 7) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (r_a[k] !== 1'b1 || v_a[first_valid + k] !== 1'b1 || d_a[first_valid + k] !== exp3[k]) begin
          errors++;
          $display("FAIL latency_word%0d: rinc=%b valid=%b dout=%h, required 1 1 %h",
                   k, r_a[k], v_a[first_valid + k], d_a[first_valid + k], exp3[k]);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int base;
    dout_ready = 1'b0;
    base = acc_total;
    for (int k = 0; k < 4; k++) mem_q.push_back(8'hA0 + 8'(k));
    for (int c = 0; c < 8; c++) begin
      @(negedge rclk);
      check_credit("bp");
      if (dout_valid) begin
        checks++;
        if (dout !== 8'hA0) begin
          errors++;
          $display("FAIL bp_hold: dout=%h, required a0", dout);
        end
      end
    end
    checks++;
    if (acc_total - base != 2 || buf_count !== 2'd2 || rinc !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: reads=%0d count=%0d rinc=%b, required 2 2 0", acc_total - base, buf_count, rinc);
    end
    dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'hA0 + 8'(k)) begin
        errors++;
        $display("FAIL bp_release%0d: valid=%b dout=%h, required 1 %h", k, dout_valid, dout, 8'hA0 + 8'(k));
      end
      @(negedge rclk);
    end
    drain();
  endtask

  task automatic test_toggle_ramp();
    got_q.delete();
    dout_ready = 1'b0;
    for (int k = 0; k < 16; k++) mem_q.push_back(8'(k));
    for (int c = 0; c < 200; c++) begin
      @(negedge rclk);
      dout_ready = ~dout_ready;
      check_credit("ramp");
      if (got_q.size() == 16) break;
    end
    checks++;
    if (got_q.size() != 16) begin
      errors++;
      $display("FAIL ramp_count: delivered=%0d, required 16", got_q.size());
    end
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== 8'(k)) begin
        errors++;
        $display("FAIL ramp_word%0d: dout=%h, required %h", k, got_q[k], 8'(k));
      end
    end
    drain();
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q [$];
    int fed = 0;
    got_q.delete();
    for (int k = 0; k < 40; k++) exp_q.push_back(DW'($urandom_range(0, 255)));
    for (int c = 0; c < 2000; c++) begin
      @(negedge rclk);
      if (fed < 40 && $urandom_range(0, 2) == 0) begin
        mem_q.push_back(exp_q[fed]);
        fed++;
      end
      force_empty = ($urandom_range(0, 7) == 0);
      dout_ready  = 1'($urandom_range(0, 1));
      check_credit("rand");
      if (got_q.size() == 40) break;
    end
    force_empty = 1'b0;
    checks++;
    if (got_q.size() != 40) begin
      errors++;
      $display("FAIL rand_count: delivered=%0d, required 40", got_q.size());
    end
    for (int k = 0; k < 40 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rand_word%0d: dout=%h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    drain();
  endtask

  task automatic test_rempty_race();
    bit seen = 0;
    got_q.delete();
    dout_ready = 1'b1;
    mem_q.push_back(8'h5A);
    mem_q.push_back(8'h5B);
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      if (rinc) begin
        seen = 1;
        force_empty = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL race_rinc: rinc never rose, required 1");
    end
    repeat (6) begin
      @(negedge rclk);
      checks++;
      if (rinc !== 1'b0) begin
        errors++;
        $display("FAIL race_blocked: rinc=%b, required 0", rinc);
      end
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL race_word: delivered=%0d first=%h, required 1 5a", got_q.size(),
               got_q.size() != 0 ? got_q[0] : 8'h00);
    end
    force_empty = 1'b0;
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[1] !== 8'h5B) begin
      errors++;
      $display("FAIL race_tail: delivered=%0d, required 2 ending 5b", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp_first;
    bit hit = 0;
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) mem_q.push_back(DW'($urandom_range(0, 255)));
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      if (buf_count == 2'd1 && inflight) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_setup: count=%0d inflight=%b, required 1 1", buf_count, inflight);
    end
    r_rst = 1'b1;
    #1;
    checks++;
    if (buf_count !== 2'd0 || dout_valid !== 1'b0 || rinc !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_clear: count=%0d valid=%b rinc=%b dout=%h, required 0 0 0 00",
               buf_count, dout_valid, rinc, dout);
    end
    repeat (2) @(negedge rclk);
    exp_first = mem_q[0];
    r_rst = 1'b0;
    got_q.delete();
    dout_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      if (got_q.size() != 0) break;
    end
    checks++;
    if (got_q.size() == 0 || got_q[0] !== exp_first) begin
      errors++;
      $display("FAIL rstmid_first: delivered=%0d first=%h, required %h",
               got_q.size(), got_q.size() != 0 ? got_q[0] : 8'h00, exp_first);
    end
    drain();
  endtask

  initial begin
    r_rst = 1'b1;
    test_reset();
    test_latency();
    test_backpressure();
    test_toggle_ramp();
    test_random();
    test_rempty_race();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
